// File: rtl/mips32_memsys.sv
// Unified instruction/data RAM plus memory-mapped I/O for the multicycle MIPS core:
// output FIFO, status register, free-running cycle counter and a program loader port.
module mips32_memsys #(
  parameter int          MEMWORDS  = 256,
  parameter int          FIFODEPTH = 8,
  parameter logic [31:0] IOBASE    = 32'hFFFF_FF00
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        memread,
  input  logic                        memwrite,
  input  logic [31:0]                 adr,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 memdata,
  output logic                        out_valid,
  output logic [31:0]                 out_data,
  input  logic                        out_ready,
  input  logic                        ld_we,
  input  logic [$clog2(MEMWORDS)-1:0] ld_addr,
  input  logic [31:0]                 ld_data
);

  localparam int          AW       = $clog2(MEMWORDS);
  localparam int          FW       = $clog2(FIFODEPTH);
  localparam int          CW       = FW + 1;
  localparam logic [31:0] RAMBYTES = 32'(MEMWORDS * 4);

  logic [31:0] ram [MEMWORDS];
  logic [31:0] fifo [FIFODEPTH];

  logic [31:0]   wadr;
  logic [AW-1:0] widx;
  logic          ram_hit, io_out, io_stat, io_cyc;
  logic          unused_adr;

  logic [FW-1:0] rptr, wptr;
  logic [CW-1:0] cnt;
  logic          ovf, full, push, pop, accept;
  logic [31:0]   cyc;
  logic [31:0]   status, rdata;

  // Byte offset within a word is irrelevant to every decode.
  assign wadr       = {adr[31:2], 2'b00};
  assign unused_adr = ^adr[1:0];
  assign widx       = adr[AW+1:2];
  assign ram_hit    = (wadr < RAMBYTES);
  assign io_out     = (wadr == IOBASE);
  assign io_stat    = (wadr == IOBASE + 32'h4);
  assign io_cyc     = (wadr == IOBASE + 32'h8);

  // Loader write is issued last so it overrides a same-word core store.
  always_ff @(posedge clk) begin
    if (memwrite && ram_hit) ram[widx] <= writedata;
    if (ld_we)               ram[ld_addr] <= ld_data;
  end

  assign out_valid = (cnt != '0);
  assign full      = (cnt == CW'(FIFODEPTH));
  assign push      = memwrite && io_out;
  assign pop       = out_valid && out_ready;
  assign accept    = push && (!full || pop);
  assign out_data  = out_valid ? fifo[rptr] : 32'h0;

  always_ff @(posedge clk) begin
    if (accept) fifo[wptr] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (accept) wptr <= wptr + FW'(1);
      if (pop)    rptr <= rptr + FW'(1);
      case ({accept, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (memwrite && io_stat)  ovf <= 1'b0;
      else if (push && !accept) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                  cyc <= 32'h0;
    else if (memwrite && io_cyc) cyc <= 32'h0;
    else                        cyc <= cyc + 32'd1;
  end

  assign status = {16'h0, 8'(cnt), 5'h0, ovf, full, ~out_valid};

  // Reads see pre-edge state; there is no forwarding of this cycle's store.
  always_comb begin
    rdata = 32'h0;
    if (ram_hit)      rdata = ram[widx];
    else if (io_stat) rdata = status;
    else if (io_cyc)  rdata = cyc;
    memdata = memread ? rdata : 32'h0;
  end

endmodule

// File: tb/tb_mips32_memsys.sv
// Directed bench for mips32_memsys: loader, RAM, FIFO, status, cycle counter, reset.
module tb_mips32_memsys;

  localparam logic [31:0] IOB = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        reset, memread, memwrite, out_ready, ld_we;
  logic [31:0] adr, writedata, ld_data, memdata, out_data;
  logic [7:0]  ld_addr;
  logic        out_valid;

  int errors = 0;
  int checks = 0;

  mips32_memsys #(.MEMWORDS(256), .FIFODEPTH(8), .IOBASE(IOB)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .adr(adr), .writedata(writedata), .memdata(memdata),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    memread = 1'b1;
    adr     = a;
    #1;
    chk(tag, memdata, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    adr       = a;
    writedata = d;
    step();
    memwrite  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    memread = 0; memwrite = 0; adr = 0; writedata = 0; out_ready = 0;
    // 1: preload during reset
    reset = 1; ld_we = 1; ld_addr = 8'd0; ld_data = 32'h2002_0005;
    step();
    ld_we = 0; reset = 0;
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_data", out_data, 32'h0);
    rd(IOB + 4, 32'h0000_0001, "rst_status");
    rd(IOB + 8, 32'h0, "rst_cycle");
    rd(32'h0, 32'h2002_0005, "preload");
    memread = 0; #1;
    chk("noread_zero", memdata, 32'h0);

    // 2: store/load, unmapped, boundary, read-during-write, loader collision
    wr(32'h10, 32'hDEAD_BEEF);
    rd(32'h13, 32'hDEAD_BEEF, "store_load");
    rd(32'h8000_0000, 32'h0, "unmapped");
    rd(IOB, 32'h0, "outdata_read");
    wr(32'h400, 32'hFFFF_FFFF);
    rd(32'h0, 32'h2002_0005, "no_alias");
    rd(32'h400, 32'h0, "ram_edge");
    memwrite = 1; adr = 32'h10; writedata = 32'h1111_1111; memread = 1; #1;
    chk("rw_old", memdata, 32'hDEAD_BEEF);
    step(); memwrite = 0;
    rd(32'h10, 32'h1111_1111, "rw_new");
    ld_we = 1; ld_addr = 8'd4; ld_data = 32'hAAAA_AAAA;
    wr(32'h10, 32'hBBBB_BBBB);
    ld_we = 0;
    rd(32'h10, 32'hAAAA_AAAA, "ld_wins");

    // 3: fill, overflow, drain, clear overflow
    for (int i = 1; i <= 8; i++) wr(IOB, i);
    rd(IOB + 4, 32'h0802, "full_status");
    chk("head1", out_data, 32'h1);
    wr(IOB, 32'd9);
    rd(IOB + 4, 32'h0806, "ovf_status");
    out_ready = 1; #1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain", out_data, i);
      step();
    end
    chk("drained_valid", {31'h0, out_valid}, 32'h0);
    chk("drained_data", out_data, 32'h0);
    rd(IOB + 4, 32'h0005, "empty_ovf");
    step();
    rd(IOB + 4, 32'h0005, "ready_empty");
    out_ready = 0;
    wr(IOB + 4, 32'h0);
    rd(IOB + 4, 32'h0001, "ovf_clear");

    // 4: push into full FIFO while popping
    for (int i = 1; i <= 8; i++) wr(IOB, i);
    out_ready = 1;
    wr(IOB, 32'd9);
    out_ready = 0;
    rd(IOB + 4, 32'h0802, "push_pop_status");
    chk("push_pop_head", out_data, 32'h2);
    out_ready = 1; #1;
    for (int i = 2; i <= 9; i++) begin
      chk("drain2", out_data, i);
      step();
    end
    out_ready = 0;
    chk("drain2_empty", {31'h0, out_valid}, 32'h0);

    // 5: cycle counter
    do_reset();
    for (int i = 0; i < 10; i++) step();
    rd(IOB + 8, 32'd10, "cycle10");
    wr(IOB + 8, 32'h55);
    rd(IOB + 8, 32'd0, "cycle_clr");
    step();
    rd(IOB + 8, 32'd1, "cycle_resume");

    // 6: reset mid-operation
    wr(IOB, 32'hA); wr(IOB, 32'hB); wr(IOB, 32'hC);
    wr(32'h10, 32'h1234_5678);
    rd(IOB + 4, 32'h0300, "pre_rst_status");
    do_reset();
    chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_data", out_data, 32'h0);
    rd(IOB + 4, 32'h0001, "mid_rst_status");
    rd(IOB + 8, 32'h0, "mid_rst_cycle");
    rd(32'h10, 32'h1234_5678, "ram_kept");
    step();
    rd(IOB + 8, 32'd1, "mid_rst_cycle1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
